mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 140 ++++++++++++++
 tb/tb_mem_responder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Single-port word memory behind a valid/ready request/response handshake.
// Define MEM_WAIT_EN to insert WAIT extra cycles before each response.
module mem_responder #(
  parameter int DEPTH = 256,
  parameter int WAIT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          IW      = $clog2(DEPTH);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state, next_state;
  logic [31:0] mem [0:DEPTH-1];

  logic          accept, commit;
  logic          cur_write, cur_err;
  logic [31:0]   cur_addr, cur_wdata;
  logic [3:0]    cur_be;
  logic [IW-1:0] cur_idx;

  assign accept = (state == S_IDLE) && req_valid;

`ifdef MEM_WAIT_EN
  localparam int            CW        = (WAIT > 0) ? $clog2(WAIT + 1) : 1;
  localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT);

  logic [CW-1:0] wait_cnt;
  logic          cap_write;
  logic [31:0]   cap_addr, cap_wdata;
  logic [3:0]    cap_be;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt  <= '0;
      cap_write <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_be    <= '0;
    end else if (accept) begin
      wait_cnt  <= WAIT_LOAD;
      cap_write <= req_write;
      cap_addr  <= req_addr;
      cap_wdata <= req_wdata;
      cap_be    <= req_be;
    end else if (state == S_WAIT) begin
      wait_cnt <= wait_cnt - 1'b1;
    end
  end

  // A zero-wait request commits on its acceptance edge, before capture.
  assign cur_write = (state == S_IDLE) ? req_write : cap_write;
  assign cur_addr  = (state == S_IDLE) ? req_addr  : cap_addr;
  assign cur_wdata = (state == S_IDLE) ? req_wdata : cap_wdata;
  assign cur_be    = (state == S_IDLE) ? req_be    : cap_be;
`else
  assign cur_write = req_write;
  assign cur_addr  = req_addr;
  assign cur_wdata = req_wdata;
  assign cur_be    = req_be;
`endif

  assign cur_err = (cur_addr[1:0] != 2'b00) || ({2'b00, cur_addr[31:2]} >= DEPTH_W);
  assign cur_idx = cur_addr[IW+1:2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  // NOTE: next_state is defaulted first so no path through the case infers a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: begin
        if (req_valid) begin
`ifdef MEM_WAIT_EN
          next_state = (WAIT_LOAD != '0) ? S_WAIT : S_RESP;
`else
          next_state = S_RESP;
`endif
        end
      end
      S_WAIT: begin
`ifdef MEM_WAIT_EN
        if (wait_cnt <= CW'(1)) next_state = S_RESP;
`else
        next_state = S_IDLE;
`endif
      end
      S_RESP:  if (rsp_ready) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == S_IDLE);
    rsp_valid = (state == S_RESP);
  end

  assign commit = (next_state == S_RESP) && (state != S_RESP);

  // NOTE: storage has no reset; contents survive reset and a write is
  // gated by reset so an edge during reset can never commit a store.
  always_ff @(posedge clk) begin
    if (commit && reset && cur_write && !cur_err) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_be[i]) mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (commit) begin
      rsp_err   <= cur_err;
      rsp_rdata <= (cur_write || cur_err) ? 32'h0 : mem[cur_idx];
    end else if ((state == S_RESP) && rsp_ready) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder; expected values are hand-computed
// constants. Latency expectations follow MEM_WAIT_EN when defined.
module tb_mem_responder;

  localparam int DEPTH  = 256;
  localparam int WAIT_P = 2;
`ifdef MEM_WAIT_EN
  localparam int W = WAIT_P;
`else
  localparam int W = 0;
`endif

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_cmp = 0;
  int n_bad = 0;

  mem_responder #(.DEPTH(DEPTH), .WAIT(WAIT_P)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one request from IDLE and returns the response and its latency
  // in edges after acceptance; lat reaches 50 if no response appears.
  task automatic transact(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output logic [31:0] rdata, output logic err,
                          output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_be = be;
    rsp_ready = 1'b0;
    @(posedge clk); #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 50);
    rdata = rsp_rdata;
    err   = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; rsp_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
    n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
    req_valid = 1'b1;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_hold_valid: got %b want 0", rsp_valid); end
    req_valid = 1'b0;
    reset = 1'b1;
    dut.mem[0] = 32'h0000_0018;
    dut.mem[1] = 32'h0;
  endtask

  task automatic test_load;
    logic [31:0] rd; logic er; int lat;
    transact(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
    n_cmp++; if (rd !== 32'h0000_0018) begin n_bad++; $display("FAIL load_rdata: got %h want 00000018", rd); end
    n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL load_err: got %b want 0", er); end
    n_cmp++; if (lat != 1 + W) begin n_bad++; $display("FAIL load_latency: got %0d want %0d", lat, 1 + W); end
  endtask

  task automatic test_store_be;
    logic [31:0] rd; logic er; int lat;
    transact(1'b1, 32'h4, 32'hAABB_CCDD, 4'b0101, rd, er, lat);
    n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL store_err: got %b want 0", er); end
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL store_rdata: got %h want 0", rd); end
    n_cmp++; if (dut.mem[1] !== 32'h00BB_00DD) begin n_bad++; $display("FAIL store_mem1: got %h want 00BB00DD", dut.mem[1]); end
    transact(1'b0, 32'h4, 32'h0, 4'h0, rd, er, lat);
    n_cmp++; if (rd !== 32'h00BB_00DD) begin n_bad++; $display("FAIL load_after_store: got %h want 00BB00DD", rd); end
  endtask

  task automatic test_be_zero;
    logic [31:0] rd; logic er; int lat;
    dut.mem[3] = 32'h1234_5678;
    transact(1'b1, 32'hC, 32'hFFFF_FFFF, 4'b0000, rd, er, lat);
    n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL be0_err: got %b want 0", er); end
    n_cmp++; if (dut.mem[3] !== 32'h1234_5678) begin n_bad++; $display("FAIL be0_mem3: got %h want 12345678", dut.mem[3]); end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic er; int lat;
    transact(1'b0, 32'h2, 32'h0, 4'h0, rd, er, lat);
    n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL misalign_load_err: got %b want 1", er); end
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL misalign_load_rdata: got %h want 0", rd); end
    transact(1'b0, 32'(4 * DEPTH), 32'h0, 4'h0, rd, er, lat);
    n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL range_load_err: got %b want 1", er); end
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL range_load_rdata: got %h want 0", rd); end
    transact(1'b1, 32'h2, 32'hFFFF_FFFF, 4'hF, rd, er, lat);
    n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL misalign_store_err: got %b want 1", er); end
    n_cmp++; if (dut.mem[0] !== 32'h0000_0018) begin n_bad++; $display("FAIL misalign_store_mem0: got %h want 00000018", dut.mem[0]); end
    transact(1'b1, 32'(4 * DEPTH), 32'hFFFF_FFFF, 4'hF, rd, er, lat);
    n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL range_store_err: got %b want 1", er); end
    n_cmp++; if (dut.mem[0] !== 32'h0000_0018) begin n_bad++; $display("FAIL range_store_mem0: got %h want 00000018", dut.mem[0]); end
  endtask

  task automatic test_hold;
    int lat;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h4; rsp_ready = 1'b0;
    @(posedge clk); #1 req_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 50);
    n_cmp++; if (lat != 1 + W) begin n_bad++; $display("FAIL hold_latency: got %0d want %0d", lat, 1 + W); end
    req_valid = 1'b1; req_addr = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL hold_valid[%0d]: got %b want 1", i, rsp_valid); end
      n_cmp++; if (rsp_rdata !== 32'h00BB_00DD) begin n_bad++; $display("FAIL hold_rdata[%0d]: got %h want 00BB00DD", i, rsp_rdata); end
      n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL hold_err[%0d]: got %b want 0", i, rsp_err); end
      n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL hold_req_ready[%0d]: got %b want 0", i, req_ready); end
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL hold_no_accept_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL hold_no_accept_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_reset_abort;
    int lat;
    @(negedge clk);
`ifdef MEM_WAIT_EN
    dut.mem[2] = 32'h1111_1111;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h8; req_wdata = 32'h0; req_be = 4'hF;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL abort_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL abort_ready: got %b want 1", req_ready); end
    @(negedge clk); @(negedge clk);
    n_cmp++; if (dut.mem[2] !== 32'h1111_1111) begin n_bad++; $display("FAIL abort_mem2: got %h want 11111111", dut.mem[2]); end
`else
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0; rsp_ready = 1'b0;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL drop_pre_valid: got %b want 1", rsp_valid); end
    reset = 1'b0;
    #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL drop_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL drop_rdata: got %h want 0", rsp_rdata); end
    @(negedge clk);
`endif
    reset = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0;
    @(posedge clk); #1 req_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 50);
    n_cmp++; if (lat != 1 + W) begin n_bad++; $display("FAIL first_edge_latency: got %0d want %0d", lat, 1 + W); end
    n_cmp++; if (rsp_rdata !== 32'h0000_0018) begin n_bad++; $display("FAIL first_edge_rdata: got %h want 00000018", rsp_rdata); end
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    int          seen, gap, cyc;
    logic [31:0] data [2];
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0; rsp_ready = 1'b1;
    seen = 0; gap = 0; cyc = 0;
    while (seen < 2 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid) begin
        data[seen] = rsp_rdata;
        seen++;
        if (seen == 1) req_addr = 32'h4;
        else           req_valid = 1'b0;
      end else if (seen == 1) begin
        gap++;
      end
    end
    req_valid = 1'b0;
    @(posedge clk); #1 rsp_ready = 1'b0;
    n_cmp++; if (seen != 2) begin n_bad++; $display("FAIL b2b_count: got %0d want 2", seen); end
    n_cmp++; if (gap != 1 + W) begin n_bad++; $display("FAIL b2b_gap: got %0d want %0d", gap, 1 + W); end
    if (seen == 2) begin
      n_cmp++; if (data[0] !== 32'h0000_0018) begin n_bad++; $display("FAIL b2b_first: got %h want 00000018", data[0]); end
      n_cmp++; if (data[1] !== 32'h00BB_00DD) begin n_bad++; $display("FAIL b2b_second: got %h want 00BB00DD", data[1]); end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store_be();
    test_be_zero();
    test_errors();
    test_hold();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
